oam_dma_ctrl: RTL and testbench



---
 rtl/oam_dma_ctrl_pkg.sv | 27 ++
 rtl/oam_dma_ctrl_if.sv | 26 ++
 rtl/oam_dma_ctrl.sv | 110 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants, state encodings and a helper for the sprite DMA controller.
package oam_dma_ctrl_pkg;

    localparam logic [15:0] DMA_TRIGGER_ADDR  = 16'h4014;
    localparam logic [15:0] DMA_OAM_DATA_ADDR = 16'h2004;
    localparam int          DMA_BYTES         = 256;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    typedef struct packed {
        logic        cpu_halt;
        logic        dma_active;
        logic [15:0] dma_addr;
        logic [7:0]  dma_wr_data;
        logic        dma_read_en;
        logic        dma_write_en;
    } dma_bus_t;

    function automatic logic is_last_byte(input logic [7:0] idx);
        return idx == 8'(DMA_BYTES - 1);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side trigger/halt signals and the DMA bus that the system mux routes to the decoder.
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wr_data;
    logic        dma_read_en;
    logic        dma_write_en;
    logic [7:0]  dma_rd_data;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_data_in, cpu_write_en, dma_rd_data,
        output cpu_halt, dma_active, dma_addr, dma_wr_data,
               dma_read_en, dma_write_en, dma_done
    );

    modport slave (
        output cpu_addr, cpu_data_in, cpu_write_en, dma_rd_data,
        input  cpu_halt, dma_active, dma_addr, dma_wr_data,
               dma_read_en, dma_write_en, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: halts the CPU and copies one 256-byte page into sprite RAM
// through the OAM data port, one read/write pair per byte.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR  = DMA_TRIGGER_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DMA_OAM_DATA_ADDR
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.master bus
);

    logic [2:0] state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       parity_q;
    logic       done_q, done_d;
    logic       trigger_s;
    dma_bus_t   out_s;

    assign trigger_s = (state_q == ST_IDLE) && bus.cpu_write_en &&
                       (bus.cpu_addr == TRIGGER_ADDR);

    // Next-state logic; triggers outside IDLE are ignored so page never reloads mid-transfer.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    page_d  = bus.cpu_data_in;
                    idx_d   = 8'd0;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (parity_q) begin
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                idx_d = idx_q + 8'd1;
                if (is_last_byte(idx_q)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; parity free-runs so the HALT cycle can pick up the odd-cycle alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= ~parity_q;
            done_q   <= done_d;
        end
    end

    // Moore output decode; only the write data passes straight through from the decoder.
    always_comb begin
        out_s = '0;
        case (state_q)
            ST_HALT, ST_ALIGN: out_s.cpu_halt = 1'b1;
            ST_READ: begin
                out_s.cpu_halt    = 1'b1;
                out_s.dma_active  = 1'b1;
                out_s.dma_addr    = {page_q, idx_q};
                out_s.dma_read_en = 1'b1;
            end
            ST_WRITE: begin
                out_s.cpu_halt     = 1'b1;
                out_s.dma_active   = 1'b1;
                out_s.dma_addr     = OAM_DATA_ADDR;
                out_s.dma_wr_data  = bus.dma_rd_data;
                out_s.dma_write_en = 1'b1;
            end
            default: out_s = '0;
        endcase
    end

    assign bus.cpu_halt     = out_s.cpu_halt;
    assign bus.dma_active   = out_s.dma_active;
    assign bus.dma_addr     = out_s.dma_addr;
    assign bus.dma_wr_data  = out_s.dma_wr_data;
    assign bus.dma_read_en  = out_s.dma_read_en;
    assign bus.dma_write_en = out_s.dma_write_en;
    assign bus.dma_done     = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: flat memory/decoder environment plus a cycle-count model of the transfer.
module tb_oam_dma_ctrl;

    logic clk = 1'b0;
    logic rst;
    oam_dma_ctrl_if bus_if();

    oam_dma_ctrl #(.TRIGGER_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    bit [7:0] mem [65536];
    bit [7:0] oam [256];
    bit [7:0] oamaddr;
    int       wr_cnt = 0;
    int       done_cnt = 0;
    int       checks = 0;
    int       errors = 0;
    bit       started = 1'b0;

    // model: transfer described by cycle number since the trigger edge
    bit       m_busy = 1'b0;
    bit       m_align = 1'b0;
    bit       m_done = 1'b0;
    int       m_c = 0;
    int       m_since = 0;
    bit [7:0] m_page = 8'd0;

    logic [15:0] env_a;
    logic        env_we, env_re;
    logic [7:0]  env_wd;

    // Bus mux + decoder + model advance, all on the active edge.
    always @(posedge clk) begin
        started = 1'b1;
        if (bus_if.dma_active) begin
            env_a = bus_if.dma_addr; env_we = bus_if.dma_write_en;
            env_re = bus_if.dma_read_en; env_wd = bus_if.dma_wr_data;
        end else begin
            env_a = bus_if.cpu_addr; env_we = bus_if.cpu_write_en & ~bus_if.cpu_halt;
            env_re = 1'b0; env_wd = bus_if.cpu_data_in;
        end
        if (env_re) bus_if.dma_rd_data <= mem[env_a];
        if (env_we && env_a == 16'h2003) oamaddr = env_wd;
        else if (env_we && env_a == 16'h2004) begin
            oam[oamaddr] = env_wd;
            oamaddr = oamaddr + 8'd1;
            wr_cnt++;
        end
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_since = 0;
        end else begin
            if (!m_busy && bus_if.cpu_write_en && bus_if.cpu_addr == 16'h4014) begin
                m_busy = 1'b1;
                m_c = 1;
                m_page = bus_if.cpu_data_in;
                m_align = ~m_since[0];
            end else if (m_busy) begin
                m_c++;
                if (m_c == 2 + int'(m_align) + 512) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_since++;
        end
    end

    logic [28:0] e_vec, a_vec;
    int          j, n;
    int          run = 0, last_run = 0, first_rd = -1;
    logic [15:0] first_rd_addr = 16'h0;

    // Per-cycle compare against the model, plus halt-run / done bookkeeping.
    always @(negedge clk) begin
        if (started) begin
            e_vec = '0;
            e_vec[28] = m_busy;
            e_vec[24] = m_done;
            j = m_c - 2 - int'(m_align);
            if (m_busy && j >= 0) begin
                n = j / 2;
                e_vec[27] = 1'b1;
                if (j % 2 == 0) begin
                    e_vec[26] = 1'b1;
                    e_vec[23:8] = {m_page, n[7:0]};
                end else begin
                    e_vec[25] = 1'b1;
                    e_vec[23:8] = 16'h2004;
                    e_vec[7:0] = mem[{m_page, n[7:0]}];
                end
            end
            a_vec = {bus_if.cpu_halt, bus_if.dma_active, bus_if.dma_read_en,
                     bus_if.dma_write_en, bus_if.dma_done, bus_if.dma_addr, bus_if.dma_wr_data};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL outputs t=%0t got %h expected %h", $time, a_vec, e_vec);
            end
            if (bus_if.dma_done) done_cnt++;
            if (bus_if.cpu_halt) begin
                if (run == 0) first_rd = -1;
                if (bus_if.dma_read_en && first_rd < 0) begin
                    first_rd = run;
                    first_rd_addr = bus_if.dma_addr;
                end
                run++;
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cycle();
        bus_if.cpu_addr = a; bus_if.cpu_data_in = d; bus_if.cpu_write_en = 1'b1;
        cycle();
        bus_if.cpu_write_en = 1'b0; bus_if.cpu_addr = 16'h0000;
    endtask

    // Trigger so that the HALT cycle sees the requested parity.
    task automatic trigger(input logic [7:0] pg, input bit want_align);
        cycle();
        if (bit'(~m_since[0]) != want_align) cycle();
        bus_if.cpu_addr = 16'h4014; bus_if.cpu_data_in = pg; bus_if.cpu_write_en = 1'b1;
        cycle();
        bus_if.cpu_write_en = 1'b0; bus_if.cpu_addr = 16'h0000;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!bus_if.dma_done && k < 1500) begin
            cycle();
            k++;
        end
        chk(name, {31'd0, bus_if.dma_done}, 32'd1);
    endtask

    initial begin
        int d0, w0, k;
        logic [7:0] pg, oa;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        rst = 1'b1;
        bus_if.cpu_addr = 16'h0; bus_if.cpu_data_in = 8'h0; bus_if.cpu_write_en = 1'b0;
        bus_if.dma_rd_data = 8'h0;
        repeat (3) cycle();
        rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_outs", {bus_if.cpu_halt, bus_if.dma_active, bus_if.dma_done, bus_if.dma_addr}, 32'd0);

        // parity-even transfer of page 0x02
        cpu_write(16'h2003, 8'h00);
        d0 = done_cnt; w0 = wr_cnt;
        trigger(8'h02, 1'b0);
        wait_done("even_done_seen");
        @(negedge clk); #1;
        chk("even_halt_len", last_run, 32'd513);
        chk("even_bytes", wr_cnt - w0, 32'd256);
        chk("even_done_once", done_cnt - d0, 32'd1);
        chk("even_oam0", {24'd0, oam[0]}, 32'h5A);
        chk("even_oam1", {24'd0, oam[1]}, 32'h5B);
        chk("even_oamFF", {24'd0, oam[255]}, 32'hA5);
        chk("even_first_rd", first_rd, 32'd1);

        // parity-odd transfer: one ALIGN cycle
        cpu_write(16'h2003, 8'h00);
        trigger(8'h02, 1'b1);
        wait_done("odd_done_seen");
        @(negedge clk); #1;
        chk("odd_halt_len", last_run, 32'd514);
        chk("odd_first_rd", first_rd, 32'd2);
        chk("odd_first_addr", {16'd0, first_rd_addr}, 32'h0200);

        // OAMADDR wrap
        cpu_write(16'h2003, 8'hF0);
        trigger(8'h03, 1'($urandom));
        wait_done("wrap_done_seen");
        @(negedge clk); #1;
        chk("wrap_F0", {24'd0, oam[8'hF0]}, {24'd0, mem[16'h0300]});
        chk("wrap_00", {24'd0, oam[8'h00]}, {24'd0, mem[16'h0310]});
        chk("wrap_EF", {24'd0, oam[8'hEF]}, {24'd0, mem[16'h03FF]});

        // retrigger mid-transfer is ignored
        cpu_write(16'h2003, 8'h00);
        trigger(8'h02, 1'b0);
        repeat (100) cycle();
        cpu_write(16'h4014, 8'h07);
        wait_done("retrig_done_seen");
        @(negedge clk); #1;
        chk("retrig_halt_len", last_run, 32'd513);
        chk("retrig_oam80", {24'd0, oam[8'h80]}, 32'hDA);

        // reset during WRITE of byte 0x40
        trigger(8'h02, 1'b0);
        k = 0;
        while (!(m_busy && (m_c - 2 - int'(m_align)) == 129) && k < 1000) begin
            cycle();
            k++;
        end
        chk("rst_reach_write40", {31'd0, bus_if.dma_write_en}, 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_outs", {bus_if.cpu_halt, bus_if.dma_active, bus_if.dma_read_en,
                         bus_if.dma_write_en, bus_if.dma_done, bus_if.dma_addr}, 32'd0);
        repeat (5) cycle();
        chk("rst_no_done", done_cnt - d0, 32'd0);
        cpu_write(16'h2003, 8'h00);
        w0 = wr_cnt;
        trigger(8'h11, 1'($urandom));
        wait_done("rst_after_done_seen");
        @(negedge clk); #1;
        chk("rst_after_bytes", wr_cnt - w0, 32'd256);

        // back-to-back: retrigger in the dma_done cycle
        trigger(8'h05, 1'($urandom));
        wait_done("b2b_first_done");
        w0 = wr_cnt;
        bus_if.cpu_addr = 16'h4014; bus_if.cpu_data_in = 8'h06; bus_if.cpu_write_en = 1'b1;
        cycle();
        bus_if.cpu_write_en = 1'b0; bus_if.cpu_addr = 16'h0000;
        @(negedge clk); #1;
        chk("b2b_halt_rises", {31'd0, bus_if.cpu_halt}, 32'd1);
        wait_done("b2b_second_done");
        @(negedge clk); #1;
        chk("b2b_bytes", wr_cnt - w0, 32'd256);

        // randomized pages, start offsets, gaps and parity
        for (int t = 0; t < 3; t++) begin
            pg = 8'($urandom_range(0, 255));
            if (pg >= 8'h20 && pg < 8'h40) pg = pg + 8'h40;
            oa = 8'($urandom);
            cpu_write(16'h2003, oa);
            repeat ($urandom_range(0, 7)) cycle();
            trigger(pg, 1'($urandom));
            wait_done("rand_done_seen");
            @(negedge clk); #1;
            for (int i = 0; i < 256; i++)
                chk("rand_oam", {24'd0, oam[8'(oa + 8'(i))]}, {24'd0, mem[{pg, 8'(i)}]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
